// File: rtl/serial_logic_unit.sv
// serial_logic_unit: bitwise AND/OR/XOR/NOR over WIDTH bits, SLICE bits per cycle, LSB-first
module serial_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             zero
);
    localparam int K = WIDTH / SLICE;
    localparam int CW = K > 1 ? $clog2(K) : 1;
    localparam logic [WIDTH-1:0] M0 = {WIDTH{1'b1}} >> (WIDTH - SLICE);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] k;
    logic [WIDTH-1:0] ra, rb, mask, f, nxt;
    logic [1:0] rop;
    logic last;
    // the full-width op is masked down to the active slice rather than part-selected by k
    assign f = rop == 2'b00 ? ra & rb : rop == 2'b01 ? ra | rb : rop == 2'b10 ? ra ^ rb : ~(ra | rb);
    assign nxt = result | (f & mask);
    assign last = k == CW'(K - 1);
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            result <= '0;
            zero <= 1'b0;
            k <= '0;
            mask <= M0;
            ra <= '0;
            rb <= '0;
            rop <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                ra <= a;
                rb <= b;
                rop <= op;
                result <= '0;
                k <= '0;
                mask <= M0;
            end
            if (state == RUN) begin
                result <= nxt;
                mask <= mask << SLICE;
                k <= last ? k : k + 1'b1;
                if (last) zero <= nxt == '0;
            end
        end
endmodule

// File: tb/tb_serial_logic_unit.sv
// tb_serial_logic_unit: model-based and directed checks of serial_logic_unit
module tb_serial_logic_unit;
    localparam int K = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [31:0] a = '0, b = '0, result;
    logic busy, done, zero;
    logic start5 = 1'b0;
    logic [1:0] op5 = 2'b00;
    logic [4:0] a5 = '0, b5 = '0, result5;
    logic busy5, done5, zero5;
    int pass_cnt = 0, total_cnt = 0, ndone = 0, cyc = 0;
    int mt = -1;
    logic [31:0] mfin = '0, mres = '0;
    logic mz = 1'b0;

    serial_logic_unit dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .result(result), .busy(busy), .done(done), .zero(zero));
    serial_logic_unit #(.WIDTH(5), .SLICE(1)) dut5 (.clk(clk), .rst(rst), .start(start5), .op(op5),
        .a(a5), .b(b5), .result(result5), .busy(busy5), .done(done5), .zero(zero5));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    function automatic logic [31:0] fop(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'b00: return x & y;
            2'b01: return x | y;
            2'b10: return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // mt counts edges since the accepted start; the result shows the low mt slices of the final value
    always @(posedge clk or posedge rst)
        if (rst) begin
            mt <= -1;
            mres <= '0;
            mz <= 1'b0;
        end else if (mt < 0) begin
            if (start) begin
                mfin <= fop(op, a, b);
                mres <= '0;
                mt <= 0;
            end
        end else begin
            if (mt < K) mres <= mfin & 32'((64'd1 << ((mt + 1) * 4)) - 64'd1);
            if (mt + 1 == K) mz <= mfin == '0;
            mt <= mt == K ? -1 : mt + 1;
        end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (!rst) begin
            chk("busy", busy, mt >= 0);
            chk("done", done, mt == K);
            chk("result", result, mres);
            chk("zero", zero, mz);
            if (done) ndone++;
        end

    task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = ~x; b = ~y; op = ~o;
    endtask

    task automatic wait_done(output int lat);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < 40);
        chk("done_seen", done, 1'b1);
        lat = c + 1;
    endtask

    task automatic run5(input logic [4:0] x, input logic [4:0] y, input logic [4:0] exp);
        int c = 0;
        @(negedge clk);
        start5 = 1'b1; op5 = 2'b00; a5 = x; b5 = y;
        @(negedge clk);
        start5 = 1'b0; a5 = ~x; b5 = ~y;
        do begin
            @(negedge clk);
            c++;
        end while (!done5 && c < 40);
        chk("w5_done_seen", done5, 1'b1);
        chk("w5_latency", c + 1, 6);
        chk("w5_result", result5, exp);
        chk("w5_zero", zero5, exp == 5'd0);
        @(negedge clk);
        chk("w5_done_single", done5, 1'b0);
    endtask

    initial begin
        int lat, n0, c1, c2, c3;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_result", result, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_done", done, 1'b0);

        n0 = ndone;
        go(2'b00, 32'hFFFFFFFF, 32'h0000FFFF);
        chk("and_busy", busy, 1'b1);
        wait_done(lat);
        chk("and_latency", lat, 9);
        chk("and_result", result, 32'h0000FFFF);
        chk("and_zero", zero, 1'b0);
        repeat (3) @(negedge clk);
        chk("and_ndone", ndone - n0, 1);
        chk("and_hold", result, 32'h0000FFFF);

        go(2'b10, 32'hA5A5A5A5, 32'hA5A5A5A5);
        wait_done(lat);
        chk("xor_result", result, 32'h0);
        chk("xor_zero", zero, 1'b1);
        repeat (2) @(negedge clk);
        chk("xor_zero_hold", zero, 1'b1);

        n0 = ndone;
        go(2'b01, 32'h00000011, 32'h10000000);
        @(negedge clk);
        start = 1'b1; a = '0; b = '0;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("or_result", result, 32'h10000011);
        repeat (4) @(negedge clk);
        chk("or_ndone", ndone - n0, 1);

        n0 = ndone;
        go(2'b11, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_result", result, 32'h0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_zero", zero, 1'b0);
        start = 1'b1;
        @(negedge clk);
        chk("rst_ignores_start", busy, 1'b0);
        start = 1'b0;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_ndone", ndone - n0, 0);
        go(2'b11, 32'h0, 32'h0);
        wait_done(lat);
        chk("nor_latency", lat, 9);
        chk("nor_result", result, 32'hFFFFFFFF);

        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'h12345678; b = 32'h12345678;
        wait_done(lat);
        c1 = cyc;
        chk("b2b_result1", result, 32'h12345678);
        wait_done(lat);
        c2 = cyc;
        chk("b2b_result2", result, 32'h12345678);
        wait_done(lat);
        c3 = cyc;
        start = 1'b0;
        chk("b2b_result3", result, 32'h12345678);
        chk("b2b_period1", c2 - c1, 10);
        chk("b2b_period2", c3 - c2, 10);
        repeat (3) @(negedge clk);
        chk("b2b_stops", busy, 1'b0);

        run5(5'b11111, 5'b11111, 5'b11111);
        run5(5'b00011, 5'b00010, 5'b00010);
        run5(5'b01100, 5'b01110, 5'b01100);
        run5(5'b01010, 5'b10001, 5'b00000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
